// File: rtl/fe_fifo_write_arbiter.sv
// Round-robin write arbiter sharing the FE capture FIFO between two requesters with
// per-requester queues and packet locking. Optional drop counters: FE_FIFO_ARB_DROP_COUNT_EN.
module fe_fifo_write_arbiter #(
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pCMD_WIDTH            = 2,
  parameter int pDEPTH                = 4
) (
  input  logic                             fe_clk,
  input  logic                             reset_i,
  input  logic                             I_flush,
  input  logic                             I_req0_wr,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_req0_time,
  input  logic [pCMD_WIDTH-1:0]            I_req0_cmd,
  input  logic                             I_req0_cont,
  input  logic                             I_req1_wr,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_req1_time,
  input  logic [pCMD_WIDTH-1:0]            I_req1_cmd,
  input  logic                             I_req1_cont,
  input  logic                             I_fifo_full,
  output logic                             O_fifo_wr,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
  output logic [pCMD_WIDTH-1:0]            O_fifo_command,
  output logic                             O_fifo_source,
  output logic                             O_req0_overflow,
  output logic                             O_req1_overflow,
  output logic [15:0]                      O_req0_drops,
  output logic [15:0]                      O_req1_drops,
  output logic                             O_busy
);

  localparam int AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = pTIMESTAMP_FULL_WIDTH + pCMD_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(pDEPTH);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t          state_q, state_d;
  logic            lastGrant_q, lastGrant_d;
  logic [EW-1:0]   mem_q [2][pDEPTH];
  logic [AW-1:0]   wrPtr_q [2];
  logic [AW-1:0]   wrPtr_d [2];
  logic [AW-1:0]   rdPtr_q [2];
  logic [AW-1:0]   rdPtr_d [2];
  logic [CW-1:0]   count_q [2];
  logic [CW-1:0]   count_d [2];
  logic [1:0]      overflow_q, overflow_d;
  logic [EW-1:0]   reqEntry [2];
  logic [1:0]      reqWr, notEmpty, push, popQ, drop;
  logic            sel, canPop, pop;
  logic [EW-1:0]   popEntry;

  logic                             fifoWr_q;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] fifoTime_q;
  logic [pCMD_WIDTH-1:0]            fifoCmd_q;
  logic                             fifoSrc_q;

  always_comb begin
    reqWr       = {I_req1_wr, I_req0_wr};
    reqEntry[0] = {I_req0_time, I_req0_cmd, I_req0_cont};
    reqEntry[1] = {I_req1_time, I_req1_cmd, I_req1_cont};
    for (int n = 0; n < 2; n++) notEmpty[n] = (count_q[n] != '0);
  end

  // Arbitration: IDLE alternates when both queues wait; LOCKn pins the grant until cont=0.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    sel         = 1'b0;
    canPop      = 1'b0;
    case (state_q)
      IDLE: begin
        canPop = |notEmpty;
        sel    = (&notEmpty) ? ~lastGrant_q : notEmpty[1];
      end
      LOCK0: begin
        sel    = 1'b0;
        canPop = notEmpty[0];
      end
      LOCK1: begin
        sel    = 1'b1;
        canPop = notEmpty[1];
      end
      default: ;
    endcase
    pop      = canPop & ~I_fifo_full & ~I_flush;
    popEntry = mem_q[sel][rdPtr_q[sel]];
    if (I_flush) begin
      state_d     = IDLE;
      lastGrant_d = 1'b1;
    end else if (pop) begin
      lastGrant_d = sel;
      if (popEntry[0]) state_d = sel ? LOCK1 : LOCK0;
      else             state_d = IDLE;
    end
  end

  // A full queue still accepts a write when it is being popped in the same cycle.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      popQ[n]       = pop & (sel == 1'(n));
      push[n]       = reqWr[n] & ~I_flush & ((count_q[n] != DEPTH_C) | popQ[n]);
      drop[n]       = reqWr[n] & ~I_flush & (count_q[n] == DEPTH_C) & ~popQ[n];
      wrPtr_d[n]    = wrPtr_q[n] + AW'(push[n]);
      rdPtr_d[n]    = rdPtr_q[n] + AW'(popQ[n]);
      count_d[n]    = count_q[n] + CW'(push[n]) - CW'(popQ[n]);
      overflow_d[n] = overflow_q[n] | drop[n];
      if (I_flush) begin
        wrPtr_d[n]    = '0;
        rdPtr_d[n]    = '0;
        count_d[n]    = '0;
        overflow_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      overflow_q  <= '0;
      for (int n = 0; n < 2; n++) begin
        wrPtr_q[n] <= '0;
        rdPtr_q[n] <= '0;
        count_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      overflow_q  <= overflow_d;
      for (int n = 0; n < 2; n++) begin
        wrPtr_q[n] <= wrPtr_d[n];
        rdPtr_q[n] <= rdPtr_d[n];
        count_q[n] <= count_d[n];
      end
    end
  end

  always_ff @(posedge fe_clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem_q[n][wrPtr_q[n]] <= reqEntry[n];
    end
  end

  // Data outputs hold their last written value whenever no pop happens.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      fifoWr_q   <= 1'b0;
      fifoTime_q <= '0;
      fifoCmd_q  <= '0;
      fifoSrc_q  <= 1'b0;
    end else begin
      fifoWr_q <= pop;
      if (pop) begin
        fifoTime_q <= popEntry[EW-1:pCMD_WIDTH+1];
        fifoCmd_q  <= popEntry[pCMD_WIDTH:1];
        fifoSrc_q  <= sel;
      end
    end
  end

`ifdef FE_FIFO_ARB_DROP_COUNT_EN
  logic [15:0] drops_q [2];
  logic [15:0] drops_d [2];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      drops_d[n] = drops_q[n];
      if (I_flush)                                drops_d[n] = '0;
      else if (drop[n] && drops_q[n] != 16'hFFFF) drops_d[n] = drops_q[n] + 16'd1;
    end
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < 2; n++) drops_q[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) drops_q[n] <= drops_d[n];
    end
  end

  assign O_req0_drops = drops_q[0];
  assign O_req1_drops = drops_q[1];
`else
  assign O_req0_drops = '0;
  assign O_req1_drops = '0;
`endif

  assign O_fifo_wr       = fifoWr_q;
  assign O_fifo_time     = fifoTime_q;
  assign O_fifo_command  = fifoCmd_q;
  assign O_fifo_source   = fifoSrc_q;
  assign O_req0_overflow = overflow_q[0];
  assign O_req1_overflow = overflow_q[1];
  assign O_busy          = (|notEmpty) | (state_q != IDLE);

endmodule
